iir_sample_sched: RTL
=====================

IIR_SAMPLE_SCHED -- requirements
Module: iir_sample_sched

Interface
- REQ-001 Parameter DATA_WIDTH, default 32, sample width of input, filter and output data.
- REQ-002 Parameter DIV_WIDTH, default 16, width of the sample-period divider.
- REQ-003 Parameter LATENCY, default 3, clk cycles from filt_valid to a valid filt_y; legal range 1..15.
- REQ-004 Parameter OFIFO_DEPTH, default 4, output FIFO entries; power of two, minimum 2.
- REQ-005 clk  input  1  single clock; all logic rises on posedge clk.
- REQ-006 rst_n  input  1  asynchronous, active-low reset.
- REQ-007 cfg_en  input  1  scheduler enable.
- REQ-008 cfg_div  input  DIV_WIDTH  sample period minus one, in clk cycles.
- REQ-009 s_valid / s_ready / s_data  input / output / input  1 / 1 / DATA_WIDTH  input sample handshake.
- REQ-010 filt_x  output  DATA_WIDTH  registered sample to the filter datapath.
- REQ-011 filt_valid  output  1  one-cycle strobe; the datapath advances its state only on this strobe.
- REQ-012 filt_y  input  DATA_WIDTH  filter result.
- REQ-013 m_valid / m_ready / m_data  output / input / output  1 / 1 / DATA_WIDTH  output sample handshake.
- REQ-014 busy  output  1  high when the state is not IDLE.
- REQ-015 underrun / overrun / rate_err  output  1 each  one-cycle event pulses.
- REQ-016 stats_clr  input  1; underrun_cnt, overrun_cnt  output  16 each  statistics (REQ-032).

Function
- REQ-017 Divider counts 0..cfg_div while cfg_en=1 and emits a tick when count==cfg_div, giving a period of cfg_div+1 cycles; cfg_div is sampled at each wrap.
- REQ-018 cfg_en=0 clears the divider; no ticks are generated.
- REQ-019 FSM states: IDLE, ISSUE, WAIT, CAPTURE.
- REQ-020 IDLE + tick goes to ISSUE.
- REQ-021 ISSUE (one cycle):
  - s_ready=1 only in this cycle.
  - If s_valid, filt_x<=s_data; otherwise filt_x<=0 and underrun pulses.
  - filt_valid pulses in the next cycle, together with the new filt_x.
  - Wait counter loads LATENCY; next state WAIT.
- REQ-022 WAIT decrements the counter and moves to CAPTURE when it reaches 1.
- REQ-023 CAPTURE (one cycle) pushes filt_y into the output FIFO and returns to IDLE.
- REQ-024 Timing: tick at cycle T gives ISSUE at T+1, filt_valid at T+2, CAPTURE at T+2+LATENCY, m_valid at T+3+LATENCY if the FIFO was empty.
- REQ-025 A tick while the state is not IDLE is dropped and pulses rate_err; legal operation requires cfg_div >= LATENCY+3.
- REQ-026 Output FIFO:
  - m_valid = not empty; m_data = head entry.
  - Pop on m_valid & m_ready.
  - CAPTURE into a full FIFO with no pop in the same cycle drops the sample and pulses overrun.
  - CAPTURE into a full FIFO with a pop in the same cycle succeeds.
- REQ-027 FIFO pointers wrap modulo OFIFO_DEPTH; full and empty are distinguished by an extra pointer bit.
- REQ-028 cfg_en falling mid-sample: the in-flight sample completes through CAPTURE; no new ISSUE follows.
- REQ-029 No arithmetic is performed on samples; data passes bit-exact.

Reset
- REQ-030 On rst_n low, all outputs are 0 immediately:
  - state=IDLE; divider, wait counter and FIFO pointers cleared.
  - filt_x, filt_valid, s_ready, m_valid, pulses and counters all 0.
- REQ-031 Reset asserted mid-sample discards the sample; FIFO contents are lost.

Configuration
- REQ-032 Macro IIR_SCHED_STATS_EN:
  - Defined: underrun_cnt and overrun_cnt are 16-bit saturating counters of the respective pulses, cleared synchronously by stats_clr; stats_clr has priority over increment.
  - Undefined: both ports exist and are tied to 0, and stats_clr is ignored.

Structure
- REQ-033 Package iir_pkg holds the FSM state enum, the default DATA_WIDTH and the OFIFO_DEPTH constant.
- REQ-034 Sub-module iir_sched_fifo implements the output FIFO; it has synchronous push/pop, full/empty outputs and async active-low reset.

Verification
- REQ-035 cfg_div=9, LATENCY=3, s_valid held, s_data=1,2,3, m_ready=1:
  - filt_valid every 10 cycles with x=1,2,3.
  - m_data equals filt_y each time, with m_valid 6 cycles after the tick.
- REQ-036 s_valid=0 at a tick: filt_x=0, underrun pulses once, underrun_cnt=1 (macro defined).
- REQ-037 m_ready=0 for 6 samples, OFIFO_DEPTH=4:
  - 4 entries held; overrun pulses twice.
  - Releasing m_ready drains the first 4 samples in order.
- REQ-038 cfg_div=3, LATENCY=3: a tick arrives during WAIT; rate_err pulses and the sample count is 1 per 2 periods.
- REQ-039 rst_n low during WAIT, then high:
  - All outputs are 0; m_valid stays 0.
  - The next tick restarts at ISSUE after cfg_div+1 cycles.
- REQ-040 Full FIFO with a simultaneous pop and CAPTURE: no overrun; the new sample is the tail entry.

Source files
------------

// File: rtl/iir_pkg.sv
// iir_pkg: shared types and default sizes for the IIR sample scheduler.
package iir_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        CAPTURE
    } state_t;

    localparam int DATA_WIDTH_DEF  = 32;
    localparam int OFIFO_DEPTH_DEF = 4;

endpackage

// File: rtl/iir_sched_fifo.sv
// iir_sched_fifo: output FIFO; one extra pointer bit distinguishes full from empty.
module iir_sched_fifo
    import iir_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = OFIFO_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]           r_wptr;
    logic [AW:0]           r_rptr;
    logic                  w_push;
    logic                  w_pop;

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

    assign o_empty = r_wptr == r_rptr;
    assign o_full  = r_wptr == {~r_rptr[AW], r_rptr[AW-1:0]};
    assign o_data  = r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/iir_sample_sched.sv
// iir_sample_sched: divider-paced sample scheduler around an external IIR datapath.
// Build option IIR_SCHED_STATS_EN enables saturating underrun/overrun counters.
module iir_sample_sched
    import iir_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int DIV_WIDTH   = 16,
    parameter int LATENCY     = 3,
    parameter int OFIFO_DEPTH = OFIFO_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_en,
    input  logic [DIV_WIDTH-1:0]  cfg_div,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic [DATA_WIDTH-1:0] filt_x,
    output logic                  filt_valid,
    input  logic [DATA_WIDTH-1:0] filt_y,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  busy,
    output logic                  underrun,
    output logic                  overrun,
    output logic                  rate_err,
    input  logic                  stats_clr,
    output logic [15:0]           underrun_cnt,
    output logic [15:0]           overrun_cnt
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DIV_WIDTH-1:0]  r_div_cnt;
    logic [DIV_WIDTH-1:0]  r_div_lim;
    logic [DIV_WIDTH-1:0]  w_div_lim;
    logic                  r_div_run;
    logic                  w_tick;
    logic [3:0]            r_wait;
    logic [DATA_WIDTH-1:0] r_filt_x;
    logic                  r_filt_valid;
    logic                  w_capture;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [DATA_WIDTH-1:0] w_fifo_data;

    // The first period after enabling uses the live cfg_div; later periods use the value latched at the wrap.
    assign w_div_lim = r_div_run ? r_div_lim : cfg_div;
    assign w_tick    = cfg_en && (r_div_cnt == w_div_lim);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
            r_div_lim <= '0;
            r_div_run <= 1'b0;
        end else if (!cfg_en) begin
            r_div_cnt <= '0;
            r_div_run <= 1'b0;
        end else begin
            r_div_run <= 1'b1;
            r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
            if (w_tick || !r_div_run) r_div_lim <= cfg_div;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_wait       <= '0;
            r_filt_x     <= '0;
            r_filt_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_filt_valid <= r_state == ISSUE;
            if (r_state == ISSUE) begin
                r_filt_x <= s_valid ? s_data : '0;
                r_wait   <= 4'(LATENCY);
            end else if (r_state == WAIT) begin
                r_wait <= r_wait - 4'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        s_ready     = 1'b0;
        underrun    = 1'b0;
        w_capture   = 1'b0;
        busy        = r_state != IDLE;
        case (r_state)
            IDLE:    w_state_nxt = w_tick ? ISSUE : IDLE;
            ISSUE: begin
                w_state_nxt = WAIT;
                s_ready     = 1'b1;
                underrun    = !s_valid;
            end
            WAIT:    w_state_nxt = (r_wait == 4'd1) ? CAPTURE : WAIT;
            CAPTURE: begin
                w_state_nxt = IDLE;
                w_capture   = 1'b1;
            end
        endcase
        rate_err = w_tick && busy;
    end

    assign filt_x     = r_filt_x;
    assign filt_valid = r_filt_valid;

    assign w_pop   = m_ready && !w_empty;
    assign w_push  = w_capture && (!w_full || w_pop);
    assign overrun = w_capture && w_full && !w_pop;
    assign m_valid = !w_empty;
    assign m_data  = w_empty ? '0 : w_fifo_data;

    iir_sched_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (OFIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (filt_y),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

`ifdef IIR_SCHED_STATS_EN
    logic [15:0] r_und_cnt;
    logic [15:0] r_ovr_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_und_cnt <= '0;
            r_ovr_cnt <= '0;
        end else if (stats_clr) begin
            r_und_cnt <= '0;
            r_ovr_cnt <= '0;
        end else begin
            if (underrun && !(&r_und_cnt)) r_und_cnt <= r_und_cnt + 16'd1;
            if (overrun && !(&r_ovr_cnt)) r_ovr_cnt <= r_ovr_cnt + 16'd1;
        end
    end

    assign underrun_cnt = r_und_cnt;
    assign overrun_cnt  = r_ovr_cnt;
`else
    logic w_unused_stats_clr;

    assign w_unused_stats_clr = stats_clr;
    assign underrun_cnt       = '0;
    assign overrun_cnt        = '0;
`endif

endmodule
